regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the core's 32x32 RV32I regfile.
- Adds a configurable number of read ports, two write ports with a fixed priority rule, and write-to-read bypass.
- Adds a background clear engine that zeroes the array one entry per cycle on request, plus a parametrised debug tap.
- Sits between decode/writeback in the pipelined core; entry 0 may be hardwired to zero for RISC-V x0.

Parameters:
- WIDTH, 32, data width of each entry
- DEPTH, 32, number of entries; power of two, >=2; AW = $clog2(DEPTH) is a localparam
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
- DBG_IDX, DEPTH-1, entry index driven on dbg_out

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- we0  in  1  write enable, port 0
- waddr0  in  AW  write address, port 0
- wdata0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1; has priority over port 0
- waddr1  in  AW  write address, port 1
- wdata1  in  WIDTH  write data, port 1
- raddr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rdata  out  NUM_RD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH]
- clr_req  in  1  single-cycle request to start a background clear
- busy  out  1  high while the clear engine is running
- clr_done  out  1  one-cycle pulse when a clear completes
- wr_conflict  out  1  registered; high for one cycle after both ports write the same address
- wr_drop  out  1  registered; high for one cycle after a write was discarded during a clear
- dbg_out  out  WIDTH  array[DBG_IDX], combinational, no bypass

Behaviour:
- Reset (reset==0 at a clk edge):
  - All entries, busy, clr_done, wr_conflict and wr_drop are set to 0; FSM goes to IDLE.
  - Reset overrides writes and clear requests in the same cycle.
- Reads are combinational, zero latency.
  - rdata[k] = array[raddr[k]].
  - If ZERO_REG and raddr[k]==0, rdata[k] = 0.
- Bypass (BYPASS=1, FSM in IDLE, address nonzero or ZERO_REG=0):
  - If we1 is set and waddr1 matches, rdata[k] = wdata1.
  - Otherwise, if we0 is set and waddr0 matches, rdata[k] = wdata0.
  - With BYPASS=0, new data is visible on the cycle after the write.
- Writes update the array at the clk edge.
  - If both ports write the same address, wdata1 is stored and wr_conflict=1 on the next cycle.
  - Writes to address 0 are discarded when ZERO_REG=1. This is not a drop and does not raise wr_drop.
- Clear FSM states are IDLE and CLEAR; pointer ptr is AW bits wide.
  - IDLE -> CLEAR on clr_req=1. ptr starts at 0, and busy=1 from the next cycle.
  - In CLEAR, array[ptr] is set to 0 each cycle and ptr increments.
  - When ptr==DEPTH-1 has been cleared, the FSM returns to IDLE with clr_done=1 and busy=0 on that same next cycle.
  - A full clear takes exactly DEPTH cycles of busy.
  - clr_req while busy is ignored; no queueing.
- Writes during CLEAR are discarded, and wr_drop=1 on the next cycle. Bypass is disabled while busy.
- Reads during CLEAR return array contents: entries below ptr read 0, the rest keep their old values.
- A reset during CLEAR aborts the clear; the array is fully zeroed by the reset itself and no clr_done pulse is generated.
- ptr wraps naturally at DEPTH-1; it is never used outside CLEAR.

Decomposition:
- Package regfile_pkg holds:
  - the clear FSM state typedef (IDLE, CLEAR);
  - localparam helpers (AW calculation);
  - the default WIDTH/DEPTH constants shared with the core.
- Sub-module regfile_clr_fsm contains the state register, ptr counter, and busy/clr_done generation. It outputs clr_en and clr_addr to the array.
- Read muxing and bypass stay in the top module, using a generate loop over NUM_RD.

Test Plan:
1. Reset low for 1 edge, then high; read all 32 addresses on both ports -> rdata = 0, dbg_out = 0, busy = 0.
2. we0=1, waddr0=5, wdata0=32'hDEADBEEF, raddr port0 = 5 in the same cycle -> rdata0 = DEADBEEF immediately (bypass); next cycle, without we, still DEADBEEF.
3. we0 to addr 7 with data 32'h1 and we1 to addr 7 with data 32'h2 simultaneously -> stored value 2, wr_conflict=1 for exactly one cycle; a write to addr 0 with ZERO_REG=1 -> reads 0, and wr_conflict/wr_drop stay 0.
4. Fill entries 1..31 with their index, then pulse clr_req -> busy=1 for 32 cycles; at cycle 10 of the clear, addr 3 reads 0 and addr 20 reads 20; clr_done pulses once; all entries read 0 afterwards.
5. During a clear, assert we1 to addr 31 with data 32'hFF, and pulse clr_req again -> wr_drop=1 next cycle, addr 31 ends at 0, and no second clear starts (busy lasts exactly 32 cycles).
6. Reset low at cycle 5 of a clear -> next cycle busy=0, all entries 0, no clr_done; a write to addr 31 then shows on dbg_out the following cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read/clear bus of the register file; master is the pipeline, slave is the array.
interface regfile_mp_if #(
  parameter int WIDTH  = regfile_pkg::RF_WIDTH,
  parameter int DEPTH  = regfile_pkg::RF_DEPTH,
  parameter int NUM_RD = 2
);
  localparam int AW = regfile_pkg::calc_aw(DEPTH);

  logic                    we0;
  logic [AW-1:0]           waddr0;
  logic [WIDTH-1:0]        wdata0;
  logic                    we1;
  logic [AW-1:0]           waddr1;
  logic [WIDTH-1:0]        wdata1;
  logic [NUM_RD*AW-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rdata;
  logic                    clr_req;
  logic                    busy;
  logic                    clr_done;
  logic                    wr_conflict;
  logic                    wr_drop;
  logic [WIDTH-1:0]        dbg_out;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req,
    input  rdata, busy, clr_done, wr_conflict, wr_drop, dbg_out
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req,
    output rdata, busy, clr_done, wr_conflict, wr_drop, dbg_out
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Background clear engine: walks ptr over every entry, one per cycle.
//   state    | meaning
//   ST_IDLE  | waiting for clr_req; array owned by the write ports
//   ST_CLEAR | zeroing array[ptr]; writes are dropped, busy high
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr_req_i,
  output logic                        clr_en_o,
  output logic [calc_aw(DEPTH)-1:0]   clr_addr_o,
  output logic                        busy_o,
  output logic                        clr_done_o
);
  localparam int AW = calc_aw(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          clr_done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_req_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clr_en_o   = busy_q;
  assign clr_addr_o = ptr_q;
  assign busy_o     = busy_q;
  assign clr_done_o = clr_done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// write ports with forwarding, background clear and a debug tap.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DBG_IDX  = DEPTH - 1
) (
  input  logic       clk,
  input  logic       reset,
  regfile_mp_if.slave bus
);
  localparam int AW = calc_aw(DEPTH);
  localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

  logic [WIDTH-1:0]             mem_q [DEPTH];
  logic                         clr_en;
  logic [AW-1:0]                clr_addr;
  logic                         wr_conflict_q;
  logic                         wr_drop_q;
  logic                         ok0, ok1;
  logic [NUM_RD-1:0][WIDTH-1:0] rdata_w;

  regfile_clr_fsm #(.DEPTH(DEPTH)) u_clr (
    .clk        (clk),
    .reset      (reset),
    .clr_req_i  (bus.clr_req),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr),
    .busy_o     (bus.busy),
    .clr_done_o (bus.clr_done)
  );

  // Writes aimed at a hardwired-zero x0 are silently ignored, never counted as drops.
  assign ok0 = !(ZERO_REG != 0 && bus.waddr0 == '0);
  assign ok1 = !(ZERO_REG != 0 && bus.waddr1 == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_conflict_q <= 1'b0;
      wr_drop_q     <= 1'b0;
    end else begin
      wr_conflict_q <= !clr_en && bus.we0 && bus.we1 && (bus.waddr0 == bus.waddr1);
      wr_drop_q     <= clr_en && ((bus.we0 && ok0) || (bus.we1 && ok1));
      if (clr_en) begin
        mem_q[clr_addr] <= '0;
      end else begin
        if (bus.we0 && ok0) mem_q[bus.waddr0] <= bus.wdata0;
        // Port 1 assigned last so it wins on a same-address collision.
        if (bus.we1 && ok1) mem_q[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             is_zero;
    logic [WIDTH-1:0] rd;

    assign ra      = bus.raddr[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);

    always_comb begin
      rd = mem_q[ra];
      if (BYPASS != 0 && !clr_en && !is_zero) begin
        if (bus.we1 && bus.waddr1 == ra)      rd = bus.wdata1;
        else if (bus.we0 && bus.waddr0 == ra) rd = bus.wdata0;
      end
      if (is_zero) rd = '0;
    end

    assign rdata_w[k] = rd;
  end

  assign bus.rdata       = rdata_w;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.wr_drop     = wr_drop_q;
  assign bus.dbg_out     = mem_q[DBG_A];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with hand-computed expectations.
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR)) bus ();

  regfile_mp #(
    .WIDTH(W), .DEPTH(D), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1), .DBG_IDX(D-1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, output logic [31:0] d);
    bus.raddr[p*AW +: AW] = a;
    #1;
    d = bus.rdata[p*W +: W];
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [31:0] d);
    bus.we0 = 1'b1; bus.waddr0 = a; bus.wdata0 = d;
    step();
    bus.we0 = 1'b0;
  endtask

  logic [31:0] d;
  int          busy_cnt;
  int          done_cnt;
  int          guard;

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0;
    bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.raddr = '0; bus.clr_req = 0;

    // 1: reset state
    step();
    reset = 1'b1;
    for (int a = 0; a < D; a++) begin
      rd(0, AW'(a), d); chk("rst_rd0", d, 32'h0);
      rd(1, AW'(a), d); chk("rst_rd1", d, 32'h0);
    end
    chk("rst_dbg", bus.dbg_out, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.clr_done}, 32'h0);
    chk("rst_conf", {31'b0, bus.wr_conflict}, 32'h0);
    chk("rst_drop", {31'b0, bus.wr_drop}, 32'h0);

    // 2: bypass then stored value
    step();
    bus.we0 = 1; bus.waddr0 = 5; bus.wdata0 = 32'hDEADBEEF;
    rd(0, 5, d); chk("byp_p0", d, 32'hDEADBEEF);
    rd(1, 5, d); chk("byp_p1", d, 32'hDEADBEEF);
    step();
    bus.we0 = 0;
    rd(0, 5, d); chk("stored5", d, 32'hDEADBEEF);

    // 3: same-address conflict, port 1 wins; x0 ignores writes
    bus.we0 = 1; bus.waddr0 = 7; bus.wdata0 = 32'h1;
    bus.we1 = 1; bus.waddr1 = 7; bus.wdata1 = 32'h2;
    rd(0, 7, d); chk("conf_byp", d, 32'h2);
    step();
    bus.we0 = 0; bus.we1 = 0;
    chk("conf_hi", {31'b0, bus.wr_conflict}, 32'h1);
    rd(0, 7, d); chk("conf_val", d, 32'h2);
    step();
    chk("conf_lo", {31'b0, bus.wr_conflict}, 32'h0);
    bus.we0 = 1; bus.waddr0 = 0; bus.wdata0 = 32'hFFFF;
    rd(0, 0, d); chk("x0_nobyp", d, 32'h0);
    step();
    bus.we0 = 0;
    rd(0, 0, d); chk("x0_rd", d, 32'h0);
    chk("x0_conf", {31'b0, bus.wr_conflict}, 32'h0);
    chk("x0_drop", {31'b0, bus.wr_drop}, 32'h0);

    // 4: fill and full clear
    for (int i = 1; i < D; i++) wr0(AW'(i), 32'(i));
    rd(1, 20, d); chk("fill20", d, 32'd20);
    chk("fill_dbg", bus.dbg_out, 32'd31);
    bus.clr_req = 1;
    step();
    bus.clr_req = 0;
    chk("clr_busy", {31'b0, bus.busy}, 32'h1);
    busy_cnt = 0; done_cnt = 0; guard = 0;
    while (bus.busy && guard < 100) begin
      busy_cnt++; guard++;
      if (busy_cnt == 10) begin
        rd(0, 3, d);  chk("mid_a3", d, 32'h0);
        rd(1, 20, d); chk("mid_a20", d, 32'd20);
        rd(0, 9, d);  chk("mid_a9", d, 32'd9);
      end
      step();
      if (bus.clr_done) done_cnt++;
    end
    chk("clr_len", 32'(busy_cnt), 32'd32);
    chk("clr_done_at_end", {31'b0, bus.clr_done}, 32'h1);
    step();
    chk("clr_done_cnt", 32'(done_cnt), 32'd1);
    chk("clr_done_lo", {31'b0, bus.clr_done}, 32'h0);
    for (int a = 0; a < D; a++) begin
      rd(a % 2, AW'(a), d); chk("post_clr", d, 32'h0);
    end

    // 5: writes dropped during clear, second request ignored
    wr0(31, 32'hAB);
    bus.clr_req = 1;
    step();
    bus.clr_req = 0;
    busy_cnt = 0; guard = 0;
    while (bus.busy && guard < 100) begin
      busy_cnt++; guard++;
      if (busy_cnt == 3) begin
        bus.we1 = 1; bus.waddr1 = 31; bus.wdata1 = 32'hFF; bus.clr_req = 1;
        rd(0, 31, d); chk("busy_nobyp", d, 32'hAB);
      end
      if (busy_cnt == 4) begin
        bus.we1 = 0; bus.clr_req = 0;
        chk("drop_hi", {31'b0, bus.wr_drop}, 32'h1);
      end
      if (busy_cnt == 5) chk("drop_lo", {31'b0, bus.wr_drop}, 32'h0);
      step();
    end
    chk("clr2_len", 32'(busy_cnt), 32'd32);
    rd(0, 31, d); chk("a31_zero", d, 32'h0);
    step(); step();
    chk("no_requeue", {31'b0, bus.busy}, 32'h0);

    // 6: reset aborts a clear
    wr0(31, 32'h55);
    wr0(10, 32'hA);
    bus.clr_req = 1;
    step();
    bus.clr_req = 0;
    step(); step(); step(); step();
    chk("abort_busy_pre", {31'b0, bus.busy}, 32'h1);
    reset = 0;
    step();
    reset = 1;
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_done", {31'b0, bus.clr_done}, 32'h0);
    rd(0, 10, d); chk("abort_a10", d, 32'h0);
    rd(1, 31, d); chk("abort_a31", d, 32'h0);
    chk("abort_dbg", bus.dbg_out, 32'h0);
    step();
    chk("abort_done2", {31'b0, bus.clr_done}, 32'h0);
    bus.we1 = 1; bus.waddr1 = 31; bus.wdata1 = 32'h12345678;
    #1;
    chk("dbg_nobyp", bus.dbg_out, 32'h0);
    step();
    bus.we1 = 0;
    chk("dbg_after", bus.dbg_out, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
